// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The IF stage looks up its PC and gets a zero-latency prediction.
// The EX stage reports each resolved branch, jal or jalr. That report trains
// the table and is compared against the prediction that travelled down the
// pipe, so a flush can be requested.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   lookup_en         : IF-stage lookup valid (low during stall)
//   lookup_pc         : IF-stage PC
//   pred_taken        : predicted taken
//   pred_target       : predicted next PC (stored target or lookup_pc+4)
//   upd_valid         : EX stage resolves a control-flow instruction
//   upd_pc/upd_target : resolved instruction PC and actual target
//   upd_taken         : actual outcome
//   upd_is_jump       : unconditional instruction flag
//   upd_pred_taken    : prediction made for this instruction in IF
//   upd_pred_target   : predicted target made for this instruction in IF
//   mispredict        : flush request
//   redirect_pc       : corrected fetch PC
//   perf_clr          : synchronous clear of the performance counters
//   lookup_cnt        : number of cycles with lookup_en high (saturating)
//   mispred_cnt       : number of cycles with mispredict high (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int XLEN    = 32,
   parameter int CNT_W   = 2,
   parameter int PERF_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookup_en,
   input  logic [XLEN-1:0]   lookup_pc,
   output logic              pred_taken,
   output logic [XLEN-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [XLEN-1:0]   upd_pc,
   input  logic [XLEN-1:0]   upd_target,
   input  logic              upd_taken,
   input  logic              upd_is_jump,
   input  logic              upd_pred_taken,
   input  logic [XLEN-1:0]   upd_pred_target,
   output logic              mispredict,
   output logic [XLEN-1:0]   redirect_pc,
   input  logic              perf_clr,
   output logic [PERF_W-1:0] lookup_cnt,
   output logic [PERF_W-1:0] mispred_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0]  CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);
   localparam logic [XLEN-1:0]   PC_STEP     = XLEN'(4);
   localparam logic [PERF_W-1:0] PERF_MAX    = {PERF_W{1'b1}};

   // Predictor storage, one slot per index.
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic             jump_q   [ENTRIES];
   logic [CNT_W-1:0] cnt_q    [ENTRIES];

   // Lookup-side address split and hit detection.
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic             lk_dir_taken;

   // Update-side address split and hit detection.
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic             up_write_entry;
   logic             up_write_cnt;
   logic [CNT_W-1:0] up_cnt_cur;
   logic [CNT_W-1:0] up_cnt_next;

   // The two low PC bits are always zero for aligned instructions, so they
   // play no part in indexing or tagging.
   logic unused_pc_low;
   assign unused_pc_low = ^{lookup_pc[1:0], upd_pc[1:0]};

   // The lookup reads the registered table directly. A same-cycle update to
   // the same index is therefore not visible until the next cycle.
   assign lk_idx       = lookup_pc[IDX_W+1:2];
   assign lk_tag       = lookup_pc[XLEN-1:IDX_W+2];
   assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_dir_taken = jump_q[lk_idx] || cnt_q[lk_idx][CNT_W-1];

   // Reset gates the prediction explicitly. This holds even in the instant
   // before the cleared table propagates.
   assign pred_taken  = !rst && lookup_en && lk_hit && lk_dir_taken;
   assign pred_target = pred_taken ? target_q[lk_idx] : (lookup_pc + PC_STEP);

   assign up_idx     = upd_pc[IDX_W+1:2];
   assign up_tag     = upd_pc[XLEN-1:IDX_W+2];
   assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign up_cnt_cur = cnt_q[up_idx];

   // A taken outcome always (re)allocates the slot. This is direct-mapped
   // replacement. A not-taken outcome only trains an entry that already
   // belongs to this PC.
   assign up_write_entry = upd_valid && upd_taken;
   assign up_write_cnt   = upd_valid && (upd_taken || up_hit);

   // Next counter value for the slot being updated. A taken hit strengthens
   // the counter. A fresh allocation starts weakly taken, so the branch
   // predicts taken next time. A not-taken hit weakens the counter. Both
   // directions saturate.
   always_comb begin
      up_cnt_next = up_cnt_cur;
      if (upd_taken) begin
         if (!up_hit) begin
            up_cnt_next = CNT_WEAK_T;
         end else if (up_cnt_cur != CNT_MAX) begin
            up_cnt_next = up_cnt_cur + CNT_W'(1);
         end
      end else if (up_cnt_cur != CNT_ZERO) begin
         up_cnt_next = up_cnt_cur - CNT_W'(1);
      end
   end

   // Table state. Reset clears the whole table asynchronously. Counters
   // return to weakly not-taken. An update presented in the same cycle as
   // reset never lands, because the reset branch wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            jump_q[i]   <= 1'b0;
            cnt_q[i]    <= CNT_WEAK_NT;
         end
      end else begin
         if (up_write_entry) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target;
            jump_q[up_idx]   <= upd_is_jump;
         end
         if (up_write_cnt) begin
            cnt_q[up_idx] <= up_cnt_next;
         end
      end
   end

   // Misprediction check against the prediction carried down the pipe. A
   // wrong direction always flushes. A correct taken direction still flushes
   // if the target differs, which covers jalr going somewhere new. This path
   // stays live during reset.
   assign mispredict = upd_valid &&
                       ((upd_pred_taken != upd_taken) ||
                        (upd_taken && (upd_pred_target != upd_target)));
   assign redirect_pc = upd_taken ? upd_target : (upd_pc + PC_STEP);

   // Lookup performance counter. A clear wins over a same-cycle increment.
   // The count sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookup_cnt <= '0;
      end else if (perf_clr) begin
         lookup_cnt <= '0;
      end else if (lookup_en && (lookup_cnt != PERF_MAX)) begin
         lookup_cnt <= lookup_cnt + PERF_W'(1);
      end
   end

   // Misprediction performance counter. It has the same clear priority and
   // the same saturation as the lookup counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mispred_cnt <= '0;
      end else if (perf_clr) begin
         mispred_cnt <= '0;
      end else if (mispredict && (mispred_cnt != PERF_MAX)) begin
         mispred_cnt <= mispred_cnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor using a scoreboard. Each stimulus step
// pushes its hand-computed expectations, tagged with the cycle they belong
// to. A monitor on the falling edge pops every expectation due in that cycle
// and compares it with the live DUT outputs. PERF_W is 3 so that counter
// saturation can be reached quickly.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   localparam int ENTRIES = 16;
   localparam int XLEN    = 32;
   localparam int CNT_W   = 2;
   localparam int PERF_W  = 3;

   localparam int SEL_PRED_TAKEN  = 0;
   localparam int SEL_PRED_TARGET = 1;
   localparam int SEL_MISPREDICT  = 2;
   localparam int SEL_REDIRECT    = 3;
   localparam int SEL_LOOKUP_CNT  = 4;
   localparam int SEL_MISPRED_CNT = 5;

   logic              clk;
   logic              rst;
   logic              lookup_en;
   logic [XLEN-1:0]   lookup_pc;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              upd_valid;
   logic [XLEN-1:0]   upd_pc;
   logic [XLEN-1:0]   upd_target;
   logic              upd_taken;
   logic              upd_is_jump;
   logic              upd_pred_taken;
   logic [XLEN-1:0]   upd_pred_target;
   logic              mispredict;
   logic [XLEN-1:0]   redirect_pc;
   logic              perf_clr;
   logic [PERF_W-1:0] lookup_cnt;
   logic [PERF_W-1:0] mispred_cnt;

   typedef struct {
      int          cyc;
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   branch_predictor #(
      .ENTRIES(ENTRIES),
      .XLEN(XLEN),
      .CNT_W(CNT_W),
      .PERF_W(PERF_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .lookup_en(lookup_en),
      .lookup_pc(lookup_pc),
      .pred_taken(pred_taken),
      .pred_target(pred_target),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_target(upd_target),
      .upd_taken(upd_taken),
      .upd_is_jump(upd_is_jump),
      .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(mispredict),
      .redirect_pc(redirect_pc),
      .perf_clr(perf_clr),
      .lookup_cnt(lookup_cnt),
      .mispred_cnt(mispred_cnt)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index that tags each expectation with the cycle it belongs to.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actualValue(input int sel);
      case (sel)
         SEL_PRED_TAKEN:  return 32'(pred_taken);
         SEL_PRED_TARGET: return pred_target;
         SEL_MISPREDICT:  return 32'(mispredict);
         SEL_REDIRECT:    return redirect_pc;
         SEL_LOOKUP_CNT:  return 32'(lookup_cnt);
         default:         return 32'(mispred_cnt);
      endcase
   endfunction

   // Monitor. On each falling edge, compare every expectation queued for the
   // current cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e   = exp_q.pop_front();
         act = actualValue(e.sel);
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h",
                     e.name, e.cyc, act, e.val);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic le, input logic [31:0] lpc,
                                input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic utk,
                                input logic ujmp, input logic uptk,
                                input logic [31:0] uptgt, input logic pclr);
      lookup_en       = le;
      lookup_pc       = lpc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_target      = utgt;
      upd_taken       = utk;
      upd_is_jump     = ujmp;
      upd_pred_taken  = uptk;
      upd_pred_target = uptgt;
      perf_clr        = pclr;
   endtask

   task automatic checkOutput(input string name, input int sel, input logic [31:0] val);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.sel  = sel;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic checkLookup(input string name, input logic tk, input logic [31:0] tgt);
      checkOutput({name, "_taken"},  SEL_PRED_TAKEN,  32'(tk));
      checkOutput({name, "_target"}, SEL_PRED_TARGET, tgt);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset held. Lookups see pc+4. A mispredict still evaluates, and the
      // update it carries is ignored.
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 0, 32'h104, 0);
      checkLookup("rst_lookup", 0, 32'h104);
      checkOutput("rst_mispredict", SEL_MISPREDICT, 1);
      checkOutput("rst_redirect", SEL_REDIRECT, 32'h80);
      checkOutput("rst_lookup_cnt", SEL_LOOKUP_CNT, 0);
      checkOutput("rst_mispred_cnt", SEL_MISPRED_CNT, 0);

      // Cold lookup after reset.
      nextCycle();
      rst = 1'b0;
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("cold", 0, 32'h104);
      checkOutput("idle_mispredict", SEL_MISPREDICT, 0);

      // First taken update. The same-cycle lookup still sees the old contents.
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 0, 32'h104, 0);
      checkLookup("no_bypass", 0, 32'h104);
      checkOutput("train_mispredict", SEL_MISPREDICT, 1);
      checkOutput("train_redirect", SEL_REDIRECT, 32'h80);

      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 1, 32'h80, 0);
      checkLookup("trained", 1, 32'h80);
      checkOutput("correct_mispredict", SEL_MISPREDICT, 0);
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 1, 32'h80, 0);
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 1, 32'h80, 0);

      // Two not-taken updates. The saturated counter goes 3 -> 2 -> 1. The
      // not-taken target must not be stored.
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h200, 0, 0, 1, 32'h80, 0);
      checkOutput("nt_mispredict", SEL_MISPREDICT, 1);
      checkOutput("nt_redirect", SEL_REDIRECT, 32'h104);
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h200, 0, 0, 1, 32'h80, 0);
      checkLookup("sat_cnt2", 1, 32'h80);
      nextCycle();
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("cnt1", 0, 32'h104);

      // Retrain to 2. A not-taken miss at the aliasing PC must not allocate.
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h100, 32'h80, 1, 0, 1, 32'h80, 0);
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h140, 32'h144, 0, 0, 0, 32'h144, 0);
      checkOutput("ntmiss_mispredict", SEL_MISPREDICT, 0);
      checkLookup("retrained", 1, 32'h80);
      nextCycle();
      applyStimulus(1, 32'h100, 1, 32'h140, 32'h400, 1, 0, 0, 32'h144, 0);
      checkLookup("no_alloc", 1, 32'h80);
      checkOutput("alias_redirect", SEL_REDIRECT, 32'h400);
      nextCycle();
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("alias_evicted", 0, 32'h104);
      nextCycle();
      applyStimulus(1, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("alias_hit", 1, 32'h400);

      // Jump entry with a wrong predicted target. Two not-taken updates then
      // drive its counter to 0.
      nextCycle();
      applyStimulus(1, 32'h208, 1, 32'h208, 32'h1000, 1, 1, 1, 32'h900, 0);
      checkOutput("jmp_mispredict", SEL_MISPREDICT, 1);
      checkOutput("jmp_redirect", SEL_REDIRECT, 32'h1000);
      checkLookup("jmp_cold", 0, 32'h20c);
      nextCycle();
      applyStimulus(1, 32'h208, 1, 32'h208, 32'h2000, 0, 1, 1, 32'h1000, 0);
      checkOutput("jmp_nt_redirect", SEL_REDIRECT, 32'h20c);
      nextCycle();
      applyStimulus(1, 32'h208, 1, 32'h208, 32'h2000, 0, 1, 1, 32'h1000, 0);
      nextCycle();
      applyStimulus(1, 32'h208, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("jmp_cnt0", 1, 32'h1000);

      // PC+4 wraps at the top of the address space on both ports.
      nextCycle();
      applyStimulus(1, 32'hffff_fffc, 1, 32'hffff_fffc, 32'h0, 0, 0, 1, 32'h10, 0);
      checkLookup("wrap", 0, 32'h0);
      checkOutput("wrap_redirect", SEL_REDIRECT, 32'h0);

      // A clear beats a simultaneous lookup and mispredict. Then 5 lookups.
      nextCycle();
      applyStimulus(1, 32'h0, 1, 32'h10, 32'h20, 1, 0, 0, 32'h14, 1);
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         applyStimulus(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
         if (i == 0) begin
            checkOutput("clr_lookup_cnt", SEL_LOOKUP_CNT, 0);
            checkOutput("clr_mispred_cnt", SEL_MISPRED_CNT, 0);
         end
      end
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("lookup_cnt5", SEL_LOOKUP_CNT, 5);
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lookup_cnt_cleared", SEL_LOOKUP_CNT, 0);

      // Nine events of each kind saturate both 3-bit counters at 7.
      for (int i = 0; i < 9; i++) begin
         nextCycle();
         applyStimulus(1, 32'h0, 1, 32'h10, 32'h20, 1, 0, 0, 32'h14, 0);
      end
      nextCycle();
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mispred_sat", SEL_MISPRED_CNT, 7);
      checkOutput("lookup_sat", SEL_LOOKUP_CNT, 7);

      // Reset pulse between edges. Its effect must be visible before the
      // next rising edge.
      nextCycle();
      applyStimulus(1, 32'h208, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("async_rst", 0, 32'h20c);
      checkOutput("async_rst_lookup_cnt", SEL_LOOKUP_CNT, 0);
      checkOutput("async_rst_mispred_cnt", SEL_MISPRED_CNT, 0);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      nextCycle();
      applyStimulus(1, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0);
      checkLookup("post_rst", 0, 32'h144);
      checkOutput("post_rst_lookup_cnt", SEL_LOOKUP_CNT, 1);

      nextCycle();
      applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
      nextCycle();
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
